// File: rtl/bus_rx_pkg.sv
// Shared types, defaults and destination-ID helpers for the bus receive port.
package bus_rx_pkg;

    localparam int unsigned PCKG_SZ = 16;
    localparam int unsigned ID_W    = 8;
    localparam logic [ID_W-1:0] BCST_ID = 8'hFF;

    typedef logic [15:0] sat_cnt_t;

    function automatic logic [ID_W-1:0] get_dest(input logic [PCKG_SZ-1:0] pkt);
        return pkt[PCKG_SZ-1 -: ID_W];
    endfunction

    function automatic logic is_hit(input logic [ID_W-1:0] dest,
                                    input logic [ID_W-1:0] id,
                                    input logic [ID_W-1:0] bcst = BCST_ID);
        return (dest == id) || (dest == bcst);
    endfunction

endpackage

// File: rtl/bus_rx_if.sv
// Bus-side delivery, consumer-side show-ahead pop and status of one receive port.
interface bus_rx_if
    import bus_rx_pkg::*;
#(
    parameter int unsigned PCKG_SZ = 16,
    parameter int unsigned DEPTH   = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               push;
    logic [PCKG_SZ-1:0] D_push;
    logic               pop;
    logic [PCKG_SZ-1:0] D_pop;
    logic               pndng;
    logic               full;
    logic [CNT_W-1:0]   count;
    sat_cnt_t           drop_cnt;
    sat_cnt_t           misroute_cnt;
    logic               misroute_err;

    modport slave (
        input  push, D_push, pop,
        output D_pop, pndng, full, count, drop_cnt, misroute_cnt, misroute_err
    );

    modport master (
        output push, D_push, pop,
        input  D_pop, pndng, full, count, drop_cnt, misroute_cnt, misroute_err
    );

endinterface

// File: rtl/bus_rx_fifo_core.sv
// Show-ahead FIFO: registered head output with 1-cycle write-to-read latency.
module bus_rx_fifo_core #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_data,
    input  logic                       rd_en,
    output logic [DW-1:0]              rd_data,
    output logic                       pndng,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_rd_data;

    logic          w_wr_fire;
    logic          w_rd_fire;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [CW-1:0] w_count_nxt;

    always_comb begin
        w_wr_fire    = wr_en && !reset;
        w_rd_fire    = rd_en && (r_count != '0);
        w_rd_ptr_nxt = w_rd_fire ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_wr_fire && !w_rd_fire) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_fire && w_rd_fire) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Head register: bypass the incoming word when it lands at the next read slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_count_nxt != '0) begin
                r_rd_data <= (w_wr_fire && (w_rd_ptr_nxt == r_wr_ptr)) ? wr_data
                                                                        : r_mem[w_rd_ptr_nxt];
            end
        end
    end

    assign rd_data = r_rd_data;
    assign count   = r_count;
    assign pndng   = (r_count != '0);
    assign full    = (r_count == CW'(DEPTH));

endmodule

// File: rtl/bus_rx_port.sv
// Receive endpoint: destination-ID filter, accept/drop/misroute decode and stats
// in front of a show-ahead FIFO.
module bus_rx_port
    import bus_rx_pkg::*;
#(
    parameter int unsigned      pckg_sz = 16,
    parameter int unsigned      depth   = 8,
    parameter int unsigned      id_w    = ID_W,
    parameter logic [id_w-1:0]  drv_id  = '0,
    parameter logic [id_w-1:0]  bcst_id = id_w'(BCST_ID)
) (
    input  logic     clk,
    input  logic     reset,
    bus_rx_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(depth) + 1;

    logic [id_w-1:0]    w_dest;
    logic               w_hit;
    logic               w_full;
    logic               w_pndng;
    logic [CNT_W-1:0]   w_count;
    logic [pckg_sz-1:0] w_rd_data;
    logic               w_accept;
    logic               w_drop;
    logic               w_misroute;

    sat_cnt_t           r_drop_cnt;
    sat_cnt_t           r_misroute_cnt;
    logic               r_misroute_err;

    always_comb begin
        w_dest     = bus.D_push[pckg_sz-1 -: id_w];
        w_hit      = is_hit(ID_W'(w_dest), ID_W'(drv_id), ID_W'(bcst_id));
        w_accept   = bus.push && w_hit && (!w_full || bus.pop);
        w_drop     = bus.push && w_hit && w_full && !bus.pop;
        w_misroute = bus.push && !w_hit;
    end

    bus_rx_fifo_core #(
        .DW    (pckg_sz),
        .DEPTH (depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_accept),
        .wr_data (bus.D_push),
        .rd_en   (bus.pop),
        .rd_data (w_rd_data),
        .pndng   (w_pndng),
        .full    (w_full),
        .count   (w_count)
    );

    // Saturating drop/misroute statistics and sticky misroute flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt     <= '0;
            r_misroute_cnt <= '0;
            r_misroute_err <= 1'b0;
        end else begin
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 16'(1);
            end
            if (w_misroute) begin
                r_misroute_err <= 1'b1;
                if (r_misroute_cnt != '1) begin
                    r_misroute_cnt <= r_misroute_cnt + 16'(1);
                end
            end
        end
    end

    assign bus.D_pop        = w_rd_data;
    assign bus.pndng        = w_pndng;
    assign bus.full         = w_full;
    assign bus.count        = w_count;
    assign bus.drop_cnt     = r_drop_cnt;
    assign bus.misroute_cnt = r_misroute_cnt;
    assign bus.misroute_err = r_misroute_err;

endmodule

// File: tb/tb_bus_rx_port.sv
// Scoreboard bench for bus_rx_port (drv_id=3, depth=8) against a queue-based model.
module tb_bus_rx_port;

    localparam int unsigned DEPTH = 8;
    localparam logic [7:0]  MY_ID = 8'h03;

    typedef struct {
        int          cyc;
        logic        pndng;
        logic        full;
        logic [3:0]  count;
        logic [15:0] dpop;
        logic [15:0] drop;
        logic [15:0] mis;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;

    bus_rx_if #(.PCKG_SZ(16), .DEPTH(DEPTH)) bif ();

    bus_rx_port #(
        .pckg_sz (16),
        .depth   (DEPTH),
        .id_w    (8),
        .drv_id  (MY_ID),
        .bcst_id (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    logic [15:0] mq[$];
    int          drop_tot = 0;
    int          mis_tot  = 0;
    logic        err_m    = 1'b0;
    logic [15:0] last_dpop = '0;

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    // Reference model: a bounded queue of stored packets plus plain totals.
    task automatic model_update(input logic rs, input logic ps, input logic [15:0] d,
                                input logic pp);
        exp_t e;
        logic hit, full_pre, do_pop, accept;
        if (rs) begin
            mq.delete();
            drop_tot  = 0;
            mis_tot   = 0;
            err_m     = 1'b0;
            last_dpop = '0;
        end else begin
            hit      = (d[15:8] == MY_ID) || (d[15:8] == 8'hFF);
            full_pre = (mq.size() == DEPTH);
            do_pop   = pp && (mq.size() > 0);
            accept   = ps && hit && (!full_pre || pp);
            if (ps && !hit) begin
                mis_tot++;
                err_m = 1'b1;
            end else if (ps && full_pre && !pp) begin
                drop_tot++;
            end
            if (do_pop) void'(mq.pop_front());
            if (accept) mq.push_back(d);
        end
        if (mq.size() > 0) last_dpop = mq[0];
        e.cyc   = cyc;
        e.pndng = (mq.size() != 0);
        e.full  = (mq.size() == DEPTH);
        e.count = 4'(mq.size());
        e.dpop  = last_dpop;
        e.drop  = sat16(drop_tot);
        e.mis   = sat16(mis_tot);
        e.err   = err_m;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rs, input logic ps, input logic [15:0] d, input logic pp);
        @(negedge clk);
        reset      = rs;
        bif.push   = ps;
        bif.D_push = d;
        bif.pop    = pp;
        @(posedge clk);
        #1;
        cyc++;
        model_update(rs, ps, d, pp);
    endtask

    // Monitor: compares DUT outputs against the oldest expected state each falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bif.pndng !== e.pndng || bif.full !== e.full || bif.count !== e.count ||
                bif.D_pop !== e.dpop || bif.drop_cnt !== e.drop ||
                bif.misroute_cnt !== e.mis || bif.misroute_err !== e.err) begin
                errors++;
                $display("FAIL state cyc%0d got pndng=%b full=%b count=%0d D_pop=%h drop=%0d mis=%0d err=%b want pndng=%b full=%b count=%0d D_pop=%h drop=%0d mis=%0d err=%b",
                         e.cyc, bif.pndng, bif.full, bif.count, bif.D_pop, bif.drop_cnt,
                         bif.misroute_cnt, bif.misroute_err, e.pndng, e.full, e.count,
                         e.dpop, e.drop, e.mis, e.err);
            end
        end
    end

    function automatic logic [15:0] rand_pkt();
        logic [7:0] dest;
        case ($urandom_range(0, 3))
            0:       dest = MY_ID;
            1:       dest = 8'hFF;
            2:       dest = 8'h05;
            default: dest = 8'($urandom);
        endcase
        return {dest, 8'($urandom)};
    endfunction

    initial begin
        int guard;
        reset      = 1'b1;
        bif.push   = 1'b0;
        bif.D_push = '0;
        bif.pop    = 1'b0;

        step(1, 0, 16'h0, 0);
        step(1, 0, 16'h0, 0);

        // Single packet in and out
        step(0, 1, 16'h03AB, 0);
        step(0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 0);

        // Broadcast accepted, foreign destination rejected
        step(0, 1, 16'hFF12, 0);
        step(0, 1, 16'h0512, 0);
        step(0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 0);

        // Overfill, then streaming push+pop across pointer wrap, then drain
        for (int i = 0; i < 9; i++) step(0, 1, {MY_ID, 8'(i)}, 0);
        for (int i = 0; i < 11; i++) step(0, 1, {8'hFF, 8'(8'h40 + i)}, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 16'h0, 1);

        // Underflow attempts, then a fresh packet
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 1);
        step(0, 1, 16'h0301, 0);
        step(0, 0, 16'h0, 1);

        // Reset mid-traffic with push and pop in the reset cycle
        for (int i = 0; i < 5; i++) step(0, 1, {MY_ID, 8'(8'h80 + i)}, 0);
        step(0, 1, 16'h0777, 0);
        step(1, 1, 16'h03EE, 1);
        step(0, 0, 16'h0, 0);

        // Randomized traffic with varying pop pressure and rare resets
        for (int i = 0; i < 3000; i++) begin
            int pop_pct;
            pop_pct = ((i / 300) % 2 == 0) ? 25 : 70;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 70), rand_pkt(),
                 ($urandom_range(0, 99) < pop_pct));
        end

        // Drop counter saturation
        step(1, 0, 16'h0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, {MY_ID, 8'(i)}, 0);
        for (int i = 0; i < 65537; i++) step(0, 1, 16'hFF00, 0);
        step(0, 0, 16'h0, 1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
